// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle for the data-memory port arbiter: two requester ports plus the
// memory-side strobes. The slave modport is the arbiter; the master modport
// is the environment (requesters and the memory returning read data).
interface dmem_port_arbiter_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic                     r0_req;
  logic                     r0_we;
  logic                     r0_be;
  logic [ADDRESS_WIDTH-1:0] r0_addr;
  logic [DATA_WIDTH-1:0]    r0_wdata;
  logic                     r0_gnt;
  logic                     r0_rvalid;
  logic [DATA_WIDTH-1:0]    r0_rdata;
  logic                     r0_err;

  logic                     r1_req;
  logic                     r1_we;
  logic                     r1_be;
  logic [ADDRESS_WIDTH-1:0] r1_addr;
  logic [DATA_WIDTH-1:0]    r1_wdata;
  logic                     r1_gnt;
  logic                     r1_rvalid;
  logic [DATA_WIDTH-1:0]    r1_rdata;
  logic                     r1_err;

  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]    mem_wdata;
  logic                     mem_we;
  logic                     mem_re;
  logic                     mem_be;
  logic [DATA_WIDTH-1:0]    mem_rdata;

  modport slave (
    input  r0_req, r0_we, r0_be, r0_addr, r0_wdata,
    output r0_gnt, r0_rvalid, r0_rdata, r0_err,
    input  r1_req, r1_we, r1_be, r1_addr, r1_wdata,
    output r1_gnt, r1_rvalid, r1_rdata, r1_err,
    output mem_addr, mem_wdata, mem_we, mem_re, mem_be,
    input  mem_rdata
  );

  modport master (
    output r0_req, r0_we, r0_be, r0_addr, r0_wdata,
    input  r0_gnt, r0_rvalid, r0_rdata, r0_err,
    output r1_req, r1_we, r1_be, r1_addr, r1_wdata,
    input  r1_gnt, r1_rvalid, r1_rdata, r1_err,
    input  mem_addr, mem_wdata, mem_we, mem_re, mem_be,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter in front of the single-port data memory.
// Port 0 = core load/store unit, port 1 = loader/debug port.
// One access in flight, 3 cycles per transaction: grant pulse, memory strobe
// cycle, response pulse. Out-of-range addresses never strobe the memory and
// are answered with err.
// Build option: define DMEM_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins
// every tie); default is round-robin between the two ports.
module dmem_port_arbiter #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_SIZE      = 1024
) (
  input logic               clk,
  input logic               rst,
  dmem_port_arbiter_if.slave bus
);
  // All outputs are registered, so the visible effect of each state shows up
  // one cycle after the state: gnt while in ACCESS, strobes while in RESP,
  // rvalid in the IDLE cycle that follows.
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam logic [ADDRESS_WIDTH-1:0] ADDR_LIMIT = ADDRESS_WIDTH'(MEM_SIZE);

  logic [1:0]               req;
  logic [1:0]               we_in;
  logic [1:0]               be_in;
  logic [ADDRESS_WIDTH-1:0] addr_in [2];
  logic [DATA_WIDTH-1:0]    wdata_in [2];
  logic                     winner;

  logic [1:0]               state_reg;
  logic                     owner_reg;
  logic                     we_reg;
  logic                     be_reg;
  logic [ADDRESS_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0]    wdata_reg;
  logic                     in_range;

  logic [1:0]               gnt_reg;
  logic [1:0]               rvalid_reg;
  logic [1:0]               err_reg;
  logic [ADDRESS_WIDTH-1:0] mem_addr_reg;
  logic [DATA_WIDTH-1:0]    mem_wdata_reg;
  logic                     mem_we_reg;
  logic                     mem_re_reg;
  logic                     mem_be_reg;

  assign req         = {bus.r1_req, bus.r0_req};
  assign we_in       = {bus.r1_we, bus.r0_we};
  assign be_in       = {bus.r1_be, bus.r0_be};
  assign addr_in[0]  = bus.r0_addr;
  assign addr_in[1]  = bus.r1_addr;
  assign wdata_in[0] = bus.r0_wdata;
  assign wdata_in[1] = bus.r1_wdata;

  assign in_range = (addr_reg < ADDR_LIMIT);

`ifdef DMEM_ARB_FIXED_PRIO_EN
  // Port 0 wins whenever it is requesting.
  assign winner = ~req[0];
`else
  logic last_winner_reg;

  // On a tie the port that did not win last time goes first.
  assign winner = (&req) ? ~last_winner_reg : ~req[0];

  // Track the most recent grant; reset favours port 0 for the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_winner_reg <= 1'b1;
    end else if (state_reg == IDLE && |req) begin
      last_winner_reg <= winner;
    end
  end
`endif

  // Transaction sequencer: arbitrate and latch, strobe memory, report back.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      owner_reg     <= 1'b0;
      we_reg        <= 1'b0;
      be_reg        <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      gnt_reg       <= 2'b00;
      rvalid_reg    <= 2'b00;
      err_reg       <= 2'b00;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      mem_we_reg    <= 1'b0;
      mem_re_reg    <= 1'b0;
      mem_be_reg    <= 1'b0;
    end else begin
      gnt_reg    <= 2'b00;
      rvalid_reg <= 2'b00;
      err_reg    <= 2'b00;
      mem_we_reg <= 1'b0;
      mem_re_reg <= 1'b0;
      mem_be_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (|req) begin
            gnt_reg   <= winner ? 2'b10 : 2'b01;
            owner_reg <= winner;
            we_reg    <= we_in[winner];
            be_reg    <= be_in[winner];
            addr_reg  <= addr_in[winner];
            wdata_reg <= wdata_in[winner];
            state_reg <= ACCESS;
          end
        end
        ACCESS: begin
          // Address and data always follow the latch; strobes only when legal.
          mem_addr_reg  <= addr_reg;
          mem_wdata_reg <= wdata_reg;
          mem_be_reg    <= be_reg;
          mem_we_reg    <= in_range & we_reg;
          mem_re_reg    <= in_range & ~we_reg;
          state_reg     <= RESP;
        end
        RESP: begin
          rvalid_reg <= owner_reg ? 2'b10 : 2'b01;
          err_reg    <= in_range ? 2'b00 : (owner_reg ? 2'b10 : 2'b01);
          state_reg  <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic [DATA_WIDTH-1:0] rdata_reg;

      // Capture the owner's result during the strobe cycle; the other port holds.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          rdata_reg <= '0;
        end else if (state_reg == RESP && owner_reg == 1'(gi)) begin
          rdata_reg <= (in_range && !we_reg) ? bus.mem_rdata : '0;
        end
      end
    end
  endgenerate

  assign bus.r0_gnt    = gnt_reg[0];
  assign bus.r1_gnt    = gnt_reg[1];
  assign bus.r0_rvalid = rvalid_reg[0];
  assign bus.r1_rvalid = rvalid_reg[1];
  assign bus.r0_err    = err_reg[0];
  assign bus.r1_err    = err_reg[1];
  assign bus.r0_rdata  = g_port[0].rdata_reg;
  assign bus.r1_rdata  = g_port[1].rdata_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_wdata = mem_wdata_reg;
  assign bus.mem_we    = mem_we_reg;
  assign bus.mem_re    = mem_re_reg;
  assign bus.mem_be    = mem_be_reg;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: reset state, directed timing cases, a table of
// single transactions, reset abort, back-to-back ties, then random traffic
// against a transaction-level model with a shadow copy of memory.
module tb_dmem_port_arbiter;
  localparam int AW       = 32;
  localparam int DW       = 32;
  localparam int MEM_SIZE = 1024;
  localparam int NCYC     = 900;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  localparam bit FIXED_PRIO = 1'b1;
`else
  localparam bit FIXED_PRIO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_port_arbiter_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  dmem_port_arbiter #(
    .ADDRESS_WIDTH(AW),
    .DATA_WIDTH(DW),
    .MEM_SIZE(MEM_SIZE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  function automatic logic [31:0] init_val(int i);
    if (i == 4) return 32'hDEADBEEF;
    return 32'h1000_0000 + 32'(i) * 32'h0001_0103;
  endfunction

  // Word memory, combinational read, byte writes land in lane addr[1:0].
  logic [31:0] mem_words [256];
  assign bus.mem_rdata = mem_words[bus.mem_addr[9:2]];
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 256; i++) mem_words[i] <= init_val(i);
    end else if (bus.mem_we) begin
      if (bus.mem_be)
        mem_words[bus.mem_addr[9:2]][{bus.mem_addr[1:0], 3'b000} +: 8] <= bus.mem_wdata[7:0];
      else
        mem_words[bus.mem_addr[9:2]] <= bus.mem_wdata;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] p2(input logic hi, input logic lo);
    return {30'd0, hi, lo};
  endfunction

  function automatic logic [31:0] onehot(input logic port);
    return port ? 32'd2 : 32'd1;
  endfunction

  task automatic idle_inputs();
    bus.r0_req = 1'b0; bus.r0_we = 1'b0; bus.r0_be = 1'b0; bus.r0_addr = '0; bus.r0_wdata = '0;
    bus.r1_req = 1'b0; bus.r1_we = 1'b0; bus.r1_be = 1'b0; bus.r1_addr = '0; bus.r1_wdata = '0;
  endtask

  task automatic set_port(input int p, input logic req, input logic we, input logic be,
                          input logic [31:0] addr, input logic [31:0] wdata);
    if (p == 0) begin
      bus.r0_req = req; bus.r0_we = we; bus.r0_be = be; bus.r0_addr = addr; bus.r0_wdata = wdata;
    end else begin
      bus.r1_req = req; bus.r1_we = we; bus.r1_be = be; bus.r1_addr = addr; bus.r1_wdata = wdata;
    end
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned r = $urandom_range(0, 9);
    if (r == 0) return 32'(MEM_SIZE) + 32'($urandom_range(0, 63));
    if (r == 1) return $urandom;
    return 32'($urandom_range(0, MEM_SIZE - 1));
  endfunction

  typedef struct {
    logic        req0, req1;
    logic        we0, be0;
    logic [31:0] addr0, wdata0;
    logic        we1, be1;
    logic [31:0] addr1, wdata1;
    logic        win;
    logic        exp_we, exp_re, exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [8];

  // Random-phase model state
  logic [31:0] shadow [256];
  logic        act [2];
  logic        rwe [2];
  logic        rbe [2];
  logic [31:0] raddr [2];
  logic [31:0] rwd [2];
  logic [31:0] exp_rdata [2];
  int          next_free;
  logic        model_last;
  logic        p_valid;
  int          p_start;
  logic        p_port;
  logic        p_we, p_be, p_err;
  logic [31:0] p_addr, p_wdata, p_rdata;

  initial begin
    idle_inputs();
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_gnt",    p2(bus.r1_gnt, bus.r0_gnt), 32'd0);
    check("rst_rvalid", p2(bus.r1_rvalid, bus.r0_rvalid), 32'd0);
    check("rst_err",    p2(bus.r1_err, bus.r0_err), 32'd0);
    check("rst_rdata0", bus.r0_rdata, 32'd0);
    check("rst_rdata1", bus.r1_rdata, 32'd0);
    check("rst_strobe", {29'd0, bus.mem_we, bus.mem_re, bus.mem_be}, 32'd0);
    check("rst_maddr",  bus.mem_addr, 32'd0);
    check("rst_mwdata", bus.mem_wdata, 32'd0);
    rst = 1'b1;

    // Single read on port 0: gnt at cycle 1, mem_re at cycle 2, rvalid at cycle 3
    set_port(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    check("a_gnt_c1", p2(bus.r1_gnt, bus.r0_gnt), 32'd1);
    check("a_re_c1",  {31'd0, bus.mem_re}, 32'd0);
    idle_inputs();
    @(negedge clk);
    check("a_gnt_c2",  p2(bus.r1_gnt, bus.r0_gnt), 32'd0);
    check("a_strobe",  {29'd0, bus.mem_we, bus.mem_re, bus.mem_be}, 32'b010);
    check("a_maddr",   bus.mem_addr, 32'h10);
    check("a_rv_c2",   p2(bus.r1_rvalid, bus.r0_rvalid), 32'd0);
    @(negedge clk);
    check("a_rvalid",  p2(bus.r1_rvalid, bus.r0_rvalid), 32'd1);
    check("a_err",     p2(bus.r1_err, bus.r0_err), 32'd0);
    check("a_rdata",   bus.r0_rdata, 32'hDEADBEEF);
    $display("txn a port=0 read addr=0x10 rdata=0x%08h", bus.r0_rdata);

`ifndef DMEM_ARB_FIXED_PRIO_EN
    // Single-transaction table; last winner is port 0 going in.
    vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b1, 32'h6,        32'hAB,
                1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h4,   32'h0,        1'b0, 1'b0, 32'h10,       32'h0,
                1'b0, 1'b0, 1'b1, 1'b0, (init_val(1) & 32'hFF00FFFF) | 32'h00AB0000};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h20,  32'h12345678, 1'b0, 1'b0, 32'h10,       32'h0,
                1'b1, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h400, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,
                1'b0, 1'b0, 1'b0, 1'b1, 32'h0};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h20,  32'h0,        1'b1, 1'b0, 32'h3FC,      32'hCAFEF00D,
                1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h20,  32'h0,        1'b0, 1'b0, 32'h3FC,      32'h0,
                1'b0, 1'b0, 1'b1, 1'b0, init_val(8)};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h3FF, 32'h0,        1'b0, 1'b0, 32'hFFFFFFFF, 32'h0,
                1'b1, 1'b0, 1'b0, 1'b1, 32'h0};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h3FF, 32'h0,        1'b1, 1'b0, 32'h400,      32'h77,
                1'b0, 1'b0, 1'b1, 1'b0, 32'hCAFEF00D};

    for (int i = 0; i < 8; i++) begin
      vec_t v;
      v = vecs[i];
      set_port(0, v.req0, v.we0, v.be0, v.addr0, v.wdata0);
      set_port(1, v.req1, v.we1, v.be1, v.addr1, v.wdata1);
      @(negedge clk);
      check($sformatf("v%0d_gnt", i), p2(bus.r1_gnt, bus.r0_gnt), onehot(v.win));
      idle_inputs();
      @(negedge clk);
      check($sformatf("v%0d_strobe", i), {29'd0, bus.mem_we, bus.mem_re, bus.mem_be},
            {29'd0, v.exp_we, v.exp_re, (v.win ? v.be1 : v.be0)});
      check($sformatf("v%0d_maddr", i), bus.mem_addr, v.win ? v.addr1 : v.addr0);
      if (v.exp_we)
        check($sformatf("v%0d_mwdata", i), bus.mem_wdata, v.win ? v.wdata1 : v.wdata0);
      @(negedge clk);
      check($sformatf("v%0d_rvalid", i), p2(bus.r1_rvalid, bus.r0_rvalid), onehot(v.win));
      check($sformatf("v%0d_err", i), p2(bus.r1_err, bus.r0_err),
            v.exp_err ? onehot(v.win) : 32'd0);
      check($sformatf("v%0d_rdata", i), v.win ? bus.r1_rdata : bus.r0_rdata, v.exp_rdata);
      $display("txn v%0d port=%0d err=%0d rdata=0x%08h", i, v.win,
               v.win ? bus.r1_err : bus.r0_err, v.win ? bus.r1_rdata : bus.r0_rdata);
    end
`endif

    // Reset during the strobe cycle of a write aborts it with no response
    set_port(1, 1'b1, 1'b1, 1'b0, 32'h40, 32'h55AA55AA);
    @(negedge clk);
    check("r_gnt", p2(bus.r1_gnt, bus.r0_gnt), 32'd2);
    idle_inputs();
    @(negedge clk);
    check("r_we_before", {31'd0, bus.mem_we}, 32'd1);
    #1 rst = 1'b0;
    #1;
    check("r_strobe_async", {29'd0, bus.mem_we, bus.mem_re, bus.mem_be}, 32'd0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check($sformatf("r_rvalid_%0d", k), p2(bus.r1_rvalid, bus.r0_rvalid), 32'd0);
    end
    rst = 1'b1;

    // Both ports held requesting: grants every 3 cycles, alternating from port 0
    set_port(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
    set_port(1, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
    for (int c = 1; c <= 12; c++) begin
      logic [31:0] eg;
      logic [31:0] er;
      @(negedge clk);
      eg = 32'd0;
      er = 32'd0;
      if (c % 3 == 1) eg = onehot(FIXED_PRIO ? 1'b0 : 1'(((c - 1) / 3) % 2));
      if (c % 3 == 0) er = onehot(FIXED_PRIO ? 1'b0 : 1'(((c - 3) / 3) % 2));
      check($sformatf("hold_gnt_c%0d", c), p2(bus.r1_gnt, bus.r0_gnt), eg);
      check($sformatf("hold_rvalid_c%0d", c), p2(bus.r1_rvalid, bus.r0_rvalid), er);
      if (c % 3 == 1) $display("txn hold cycle=%0d gnt=%0d%0d", c, bus.r1_gnt, bus.r0_gnt);
    end
    idle_inputs();
    repeat (4) @(negedge clk);

    // Random traffic against the transaction-level model
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
    for (int p = 0; p < 2; p++) begin
      act[p] = 1'b0; rwe[p] = 1'b0; rbe[p] = 1'b0; raddr[p] = '0; rwd[p] = '0; exp_rdata[p] = '0;
    end
    next_free  = 0;
    model_last = 1'b1;
    p_valid    = 1'b0;
    p_start    = 0;
    p_port     = 1'b0;
    p_we = 1'b0; p_be = 1'b0; p_err = 1'b0;
    p_addr = '0; p_wdata = '0; p_rdata = '0;

    for (int c = 0; c < NCYC; c++) begin
      logic [31:0] e_gnt, e_rv, e_err, e_str;
      int d;
      logic w;
      e_gnt = 0; e_rv = 0; e_err = 0; e_str = 0;
      d = p_valid ? (c - p_start) : 0;
      if (p_valid && d == 1) e_gnt = onehot(p_port);
      if (p_valid && d == 2) e_str = {29'd0, p_we & ~p_err, ~p_we & ~p_err, p_be};
      if (p_valid && d == 3) begin
        e_rv  = onehot(p_port);
        e_err = p_err ? onehot(p_port) : 32'd0;
        exp_rdata[p_port] = p_rdata;
        $display("txn rnd cycle=%0d port=%0d we=%0d be=%0d addr=0x%08h err=%0d rdata=0x%08h",
                 c, p_port, p_we, p_be, p_addr, p_err, p_rdata);
      end
      check("rnd_gnt",    p2(bus.r1_gnt, bus.r0_gnt), e_gnt);
      check("rnd_rvalid", p2(bus.r1_rvalid, bus.r0_rvalid), e_rv);
      check("rnd_err",    p2(bus.r1_err, bus.r0_err), e_err);
      check("rnd_strobe", {29'd0, bus.mem_we, bus.mem_re, bus.mem_be}, e_str);
      check("rnd_rdata0", bus.r0_rdata, exp_rdata[0]);
      check("rnd_rdata1", bus.r1_rdata, exp_rdata[1]);
      if (p_valid && d == 2) begin
        check("rnd_maddr", bus.mem_addr, p_addr);
        if (p_we) check("rnd_mwdata", bus.mem_wdata, p_wdata);
      end

      // Requesters: hold until granted, sometimes give up early, then maybe reissue
      for (int p = 0; p < 2; p++) begin
        if (p_valid && d == 1 && p_port == 1'(p)) act[p] = 1'b0;
        else if (act[p] && $urandom_range(0, 15) == 0) act[p] = 1'b0;
        if (!act[p] && c < NCYC - 8 && $urandom_range(0, 2) == 0) begin
          act[p]   = 1'b1;
          rwe[p]   = 1'($urandom_range(0, 1));
          rbe[p]   = 1'($urandom_range(0, 1));
          raddr[p] = rand_addr();
          rwd[p]   = $urandom;
        end
        set_port(p, act[p], rwe[p], rbe[p], raddr[p], rwd[p]);
      end

      // Arbiter is free every third cycle after a grant
      if (c >= next_free && (act[0] || act[1])) begin
        if (act[0] && act[1]) w = FIXED_PRIO ? 1'b0 : ~model_last;
        else w = act[1];
        model_last = w;
        p_valid = 1'b1;
        p_start = c;
        p_port  = w;
        p_we    = rwe[w];
        p_be    = rbe[w];
        p_addr  = raddr[w];
        p_wdata = rwd[w];
        p_err   = (p_addr >= 32'(MEM_SIZE));
        p_rdata = (!p_we && !p_err) ? shadow[p_addr[9:2]] : 32'd0;
        if (p_we && !p_err) begin
          if (p_be) shadow[p_addr[9:2]][{p_addr[1:0], 3'b000} +: 8] = p_wdata[7:0];
          else shadow[p_addr[9:2]] = p_wdata;
        end
        next_free = c + 3;
      end
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
